// File: rtl/enable_div_pkg.sv
// enable_div_pkg: shared constants for the programmable clock-enable generator.
// Optional mid-period output is enabled by defining ENABLE_DIV_HALF_EN (default off).
package enable_div_pkg;
    localparam int ENABLE_DIV_PIX_100M_25M = 3;
endpackage

// File: rtl/enable_div_mod_counter.sv
// mod_counter: modulo counter 0..i_max with sync clear and increment enable.
module mod_counter
    import enable_div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_sclr,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_max,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_wrap_next
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign o_wrap_next = i_inc && !i_sclr && (cnt_q == i_max);

    always_comb begin
        cnt_d = cnt_q;
        if (i_sclr || o_wrap_next) cnt_d = '0;
        else if (i_inc)            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge i_rst)
        if (i_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;

    assign o_cnt = cnt_q;
endmodule

// File: rtl/enable_div.sv
// enable_div: runtime-programmable clock enable with shadowed divisor applied on wrap.
// Define ENABLE_DIV_HALF_EN to add the o_en_half mid-period pulse.
module enable_div
    import enable_div_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int DIV_DEFAULT = 2**WIDTH-1
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_sclr,
    input  logic             i_run,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_div,
    output logic             o_en,
`ifdef ENABLE_DIV_HALF_EN
    output logic             o_en_half,
`endif
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_busy,
    output logic             o_wrap
);
    logic [WIDTH-1:0] div_q, div_d, pend_q, pend_d;
    logic             busy_q, busy_d, wrap_q;
    logic             wrap_next;

    mod_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_sclr     (i_sclr),
        .i_inc      (i_run),
        .i_max      (div_q),
        .o_cnt      (o_cnt),
        .o_wrap_next(wrap_next)
    );

    // A clear applies a simultaneous load directly, else any pending value.
    always_comb begin
        pend_d = i_load ? i_div : pend_q;
        div_d  = div_q;
        busy_d = busy_q;
        if (i_sclr) begin
            div_d  = i_load ? i_div : (busy_q ? pend_q : div_q);
            busy_d = 1'b0;
        end else begin
            if (wrap_next && busy_q) div_d = pend_q;
            busy_d = i_load ? 1'b1 : (wrap_next ? 1'b0 : busy_q);
        end
    end

    always_ff @(posedge clk or posedge i_rst)
        if (i_rst) begin
            div_q  <= WIDTH'(DIV_DEFAULT);
            pend_q <= '0;
            busy_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            pend_q <= pend_d;
            busy_q <= busy_d;
            wrap_q <= wrap_next;
        end

    assign o_en   = i_run && (o_cnt == '0);
    assign o_busy = busy_q;
    assign o_wrap = wrap_q;

`ifdef ENABLE_DIV_HALF_EN
    logic [WIDTH:0] half_pt;
    assign half_pt   = ({1'b0, div_q} + 1'b1) >> 1;
    assign o_en_half = i_run && ({1'b0, o_cnt} == half_pt);
`endif
endmodule

// File: tb/tb_enable_div.sv
// tb_enable_div: directed scoreboard bench for enable_div (WIDTH=4, DIV_DEFAULT=3).
module tb_enable_div;
    logic       clk = 1'b0;
    logic       i_rst = 1'b1, i_sclr = 1'b0, i_run = 1'b1, i_load = 1'b0;
    logic [3:0] i_div = '0;
    logic       o_en, o_busy, o_wrap;
    logic [3:0] o_cnt;
`ifdef ENABLE_DIV_HALF_EN
    logic       o_en_half;
`endif

    typedef struct { logic en; logic [3:0] cnt; logic busy; logic wrap; } exp_t;
    exp_t sb[$];
    int compared = 0, mismatched = 0;

    enable_div #(.WIDTH(4), .DIV_DEFAULT(3)) dut (
        .clk(clk), .i_rst(i_rst), .i_sclr(i_sclr), .i_run(i_run), .i_load(i_load),
        .i_div(i_div), .o_en(o_en),
`ifdef ENABLE_DIV_HALF_EN
        .o_en_half(o_en_half),
`endif
        .o_cnt(o_cnt), .o_busy(o_busy), .o_wrap(o_wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, ".en"},   int'(o_en),   int'(e.en));
        chk({tag, ".cnt"},  int'(o_cnt),  int'(e.cnt));
        chk({tag, ".busy"}, int'(o_busy), int'(e.busy));
        chk({tag, ".wrap"}, int'(o_wrap), int'(e.wrap));
    endtask

    // Drive inputs for one edge, queue the expected post-edge outputs, then compare.
    task automatic cyc(input string tag, input logic run, input logic sclr, input logic ld,
                       input logic [3:0] dv, input logic en, input logic [3:0] cnt,
                       input logic busy, input logic wrap);
        i_run = run; i_sclr = sclr; i_load = ld; i_div = dv;
        sb.push_back('{en, cnt, busy, wrap});
        @(posedge clk); #1;
        check_pop(tag);
        i_sclr = 1'b0; i_load = 1'b0;
    endtask

    initial begin
        #3;
        sb.push_back('{1'b1, 4'd0, 1'b0, 1'b0});
        check_pop("reset");
        @(negedge clk); i_rst = 1'b0;
        @(negedge clk);
        cyc("sclr", 1, 1, 0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 8; k++)
            cyc("p4", 1, 0, 0, 0, k % 4 == 0, 4'(k % 4), 0, k % 4 == 0);
        cyc("p4b", 1, 0, 0, 0, 0, 1, 0, 0);
        cyc("ld5", 1, 0, 1, 5, 0, 2, 1, 0);
        cyc("ld5w", 1, 0, 0, 0, 0, 3, 1, 0);
        cyc("ld5a", 1, 0, 0, 0, 1, 0, 0, 1);
        for (int k = 1; k <= 12; k++)
            cyc("p6", 1, 0, 0, 0, k % 6 == 0, 4'(k % 6), 0, k % 6 == 0);
        cyc("ld5b", 1, 0, 1, 5, 0, 1, 1, 0);
        cyc("ld1", 1, 0, 1, 1, 0, 2, 1, 0);
        for (int k = 3; k <= 5; k++) cyc("ld1w", 1, 0, 0, 0, 0, 4'(k), 1, 0);
        cyc("ld1a", 1, 0, 0, 0, 1, 0, 0, 1);
        for (int k = 1; k <= 4; k++)
            cyc("p2", 1, 0, 0, 0, k % 2 == 0, 4'(k % 2), 0, k % 2 == 0);
        cyc("ld3", 1, 0, 1, 3, 0, 1, 1, 0);
        cyc("ld3a", 1, 0, 0, 0, 1, 0, 0, 1);
        cyc("c1", 1, 0, 0, 0, 0, 1, 0, 0);
        cyc("c2", 1, 0, 0, 0, 0, 2, 0, 0);
        for (int k = 0; k < 5; k++) cyc("pause", 0, 0, 0, 0, 0, 2, 0, 0);
        cyc("res3", 1, 0, 0, 0, 0, 3, 0, 0);
        cyc("res0", 1, 0, 0, 0, 1, 0, 0, 1);
        cyc("sclr_ld0", 1, 1, 1, 0, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) cyc("div0", 1, 0, 0, 0, 1, 0, 0, 1);
        cyc("ldwrap", 1, 0, 1, 3, 1, 0, 1, 1);
        cyc("ldwrap_a", 1, 0, 0, 0, 1, 0, 0, 1);
        cyc("ld7", 1, 0, 1, 7, 0, 1, 1, 0);
        cyc("ld7w", 1, 0, 0, 0, 0, 2, 1, 0);
`ifdef ENABLE_DIV_HALF_EN
        chk("half_at2", int'(o_en_half), 1);
`endif
        #2 i_rst = 1'b1;
        #1;
        sb.push_back('{1'b1, 4'd0, 1'b0, 1'b0});
        check_pop("async_rst");
        @(negedge clk); i_rst = 1'b0;
        for (int k = 1; k <= 8; k++)
            cyc("post_rst", 1, 0, 0, 0, k % 4 == 0, 4'(k % 4), 0, k % 4 == 0);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
